// File: rtl/sub_32bit_seq_if.sv
// Handshake and operand/result bundle for the sliced sequential subtractor.
interface sub_32bit_seq_if #(
   parameter int unsigned DATA_W = 32
);
   logic              start;
   logic [DATA_W-1:0] ain;
   logic [DATA_W-1:0] bin;
   logic              bin_in;
   logic              busy;
   logic              done;
   logic [DATA_W-1:0] diff;
   logic              bout;
   logic              ovf;

   modport master (
      output start, ain, bin, bin_in,
      input  busy, done, diff, bout, ovf
   );

   modport slave (
      input  start, ain, bin, bin_in,
      output busy, done, diff, bout, ovf
   );
endinterface

// File: rtl/sub_32bit_seq.sv
// Multi-cycle subtractor: diff = ain - bin - bin_in, SLICE_W bits per clock,
// LSB slice first, with a registered borrow (held as carry) between slices.
module sub_32bit_seq #(
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned SLICE_W = 8
) (
   input logic         clk,
   input logic         rst,
   sub_32bit_seq_if.slave bus
);
   localparam int unsigned NSLICE = DATA_W / SLICE_W;
   localparam int unsigned K_W    = (NSLICE > 1) ? $clog2(NSLICE) : 1;

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t              state_q, state_d;
   logic [DATA_W-1:0]   a_q, a_d;
   logic [DATA_W-1:0]   b_q, b_d;
   logic [K_W-1:0]      k_q, k_d;
   logic                c_q, c_d;
   logic [DATA_W-1:0]   diff_q, diff_d;
   logic                bout_q, bout_d;
   logic                ovf_q, ovf_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic [SLICE_W:0]    slice_sum;
   int unsigned         off;
   logic                accept;

   // State and datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         k_q     <= '0;
         c_q     <= 1'b0;
         diff_q  <= '0;
         bout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         k_q     <= k_d;
         c_q     <= c_d;
         diff_q  <= diff_d;
         bout_q  <= bout_d;
         ovf_q   <= ovf_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   // Next state, slice arithmetic (a + ~b + c) and registered-output decode
   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      b_d       = b_q;
      k_d       = k_q;
      c_d       = c_q;
      diff_d    = diff_q;
      bout_d    = bout_q;
      ovf_d     = ovf_q;
      accept    = 1'b0;
      off       = 32'(k_q) * SLICE_W;
      slice_sum = {1'b0, a_q[off +: SLICE_W]} + {1'b0, ~b_q[off +: SLICE_W]}
                + (SLICE_W+1)'(c_q);

      case (state_q)
         IDLE: accept = bus.start;
         DONE: begin
            state_d = IDLE;
            accept  = bus.start;
         end
         CALC: begin
            diff_d[off +: SLICE_W] = slice_sum[SLICE_W-1:0];
            c_d = slice_sum[SLICE_W];
            k_d = k_q + K_W'(1);
            if (k_q == K_W'(NSLICE - 1)) begin
               state_d = DONE;
               k_d     = '0;
               bout_d  = ~slice_sum[SLICE_W];
               ovf_d   = (a_q[DATA_W-1] != b_q[DATA_W-1]) &&
                         (slice_sum[SLICE_W-1] != a_q[DATA_W-1]);
            end
         end
         default: state_d = IDLE;
      endcase

      // Carry-in of the complement form is the inverted borrow-in
      if (accept) begin
         state_d = CALC;
         a_d     = bus.ain;
         b_d     = bus.bin;
         c_d     = ~bus.bin_in;
         k_d     = '0;
      end

      busy_d = (state_d == CALC);
      done_d = (state_d == DONE);
   end

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.diff = diff_q;
   assign bus.bout = bout_q;
   assign bus.ovf  = ovf_q;
endmodule
